// File: rtl/registro_jogadores_if.sv
// Strobe/flag bundle between the game control FSM (master) and the
// player-state datapath (slave).
interface registro_jogadores_if;
    logic       rst_global;
    logic       e_seed_reg;
    logic [7:0] seed;
    logic       zera_CJ;
    logic       inc_jogador;
    logic       processar_acao;
    logic       votacao;
    logic [2:0] alvo;
    logic       confirma;
    logic       avaliar_eliminacao;
    logic       morra;

    logic [2:0] jogador_atual;
    logic       CJ_fim;
    logic       jogador_vivo;
    logic [1:0] classe_atual;
    logic       jogou;
    logic       votou;
    logic       acertou;
    logic       houve_morte;
    logic [2:0] morto_noite;
    logic [4:0] vivos;
    logic       sinal_lobo_ganhou;

    modport master (
        output rst_global, e_seed_reg, seed, zera_CJ, inc_jogador,
               processar_acao, votacao, alvo, confirma,
               avaliar_eliminacao, morra,
        input  jogador_atual, CJ_fim, jogador_vivo, classe_atual, jogou,
               votou, acertou, houve_morte, morto_noite, vivos,
               sinal_lobo_ganhou
    );

    modport slave (
        input  rst_global, e_seed_reg, seed, zera_CJ, inc_jogador,
               processar_acao, votacao, alvo, confirma,
               avaliar_eliminacao, morra,
        output jogador_atual, CJ_fim, jogador_vivo, classe_atual, jogou,
               votou, acertou, houve_morte, morto_noite, vivos,
               sinal_lobo_ganhou
    );
endinterface

// File: rtl/registro_jogadores.sv
// Player-state datapath for a 5-player game (one wolf, one doctor, three
// citizens): roles, alive mask, player counter, night targets and day vote.
module registro_jogadores (
    input  logic                 clock,
    input  logic                 reset,
    registro_jogadores_if.slave  bus
);
    localparam logic [2:0] ULTIMO_JOG = 3'd4;
    // Doctor "no target" marker; never equals a wolf target, so no false save.
    localparam logic [2:0] SEM_ALVO   = 3'd7;

    logic [2:0] jogador_atual;
    logic [4:0] vivos;
    logic [2:0] lobo_idx;
    logic [2:0] medico_idx;
    logic [2:0] voto;
    logic [2:0] morto_noite;
    logic [2:0] alvo_lobo;
    logic [2:0] alvo_medico;
    logic       lobo_escolheu;
    logic       jogou;
    logic       votou;
    logic       houve_morte;

    logic [7:0] vivos_ext;
    logic       alvo_valido;
    logic       eh_lobo;
    logic       eh_medico;
    logic       acao_noite;
    logic       aceita_lobo;
    logic       aceita_medico;
    logic       aceita_noite;
    logic       aceita_voto;
    logic       mata_noite;
    logic [4:0] mascara_morte;
    logic [2:0] lobo_seed;
    logic [3:0] soma_medico;
    logic [2:0] medico_seed;

    assign vivos_ext   = {3'b000, vivos};
    assign alvo_valido = (bus.alvo < 3'd5) && vivos_ext[bus.alvo];
    assign eh_lobo     = (jogador_atual == lobo_idx);
    assign eh_medico   = (jogador_atual == medico_idx);

    // Citizens accept any valid target too, so the table never reveals roles.
    assign acao_noite    = bus.processar_acao && bus.confirma && !jogou && alvo_valido;
    assign aceita_lobo   = acao_noite && eh_lobo && (bus.alvo != lobo_idx);
    assign aceita_medico = acao_noite && !eh_lobo && eh_medico;
    assign aceita_noite  = aceita_lobo || (acao_noite && !eh_lobo);
    assign aceita_voto   = bus.votacao && bus.confirma && !votou && alvo_valido;

    assign mata_noite    = bus.avaliar_eliminacao && lobo_escolheu &&
                           (alvo_lobo != alvo_medico);
    assign mascara_morte = (mata_noite ? (5'b00001 << alvo_lobo) : 5'b00000) |
                           ((bus.morra && votou) ? (5'b00001 << voto) : 5'b00000);

    // Role derivation from the seed; the doctor offset of 1..4 keeps it off the wolf.
    always_comb begin
        lobo_seed   = (bus.seed[2:0] >= 3'd5) ? (bus.seed[2:0] - 3'd5) : bus.seed[2:0];
        soma_medico = {1'b0, lobo_seed} + 4'd1 + {2'b00, bus.seed[5:4]};
        medico_seed = soma_medico[2:0];
        if (soma_medico >= 4'd5) begin
            medico_seed = soma_medico[2:0] - 3'd5;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset || bus.rst_global) begin
            jogador_atual <= 3'd0;
            vivos         <= 5'b11111;
            lobo_idx      <= 3'd0;
            medico_idx    <= 3'd1;
            voto          <= 3'd0;
            morto_noite   <= 3'd0;
            alvo_lobo     <= 3'd0;
            alvo_medico   <= SEM_ALVO;
            lobo_escolheu <= 1'b0;
            jogou         <= 1'b0;
            votou         <= 1'b0;
            houve_morte   <= 1'b0;
        end else begin
            vivos <= vivos & ~mascara_morte;
            if (bus.avaliar_eliminacao) begin
                houve_morte   <= mata_noite;
                lobo_escolheu <= 1'b0;
                if (mata_noite) begin
                    morto_noite <= alvo_lobo;
                end
            end
            if (aceita_lobo) begin
                alvo_lobo     <= bus.alvo;
                lobo_escolheu <= 1'b1;
            end
            if (aceita_medico) begin
                alvo_medico <= bus.alvo;
            end
            if (aceita_noite) begin
                jogou <= 1'b1;
            end
            if (aceita_voto) begin
                voto  <= bus.alvo;
                votou <= 1'b1;
            end
            // Later assignments here take priority over the captures above.
            if (bus.e_seed_reg) begin
                lobo_idx   <= lobo_seed;
                medico_idx <= medico_seed;
                vivos      <= 5'b11111;
            end else if (bus.zera_CJ) begin
                jogador_atual <= 3'd0;
                jogou         <= 1'b0;
                votou         <= 1'b0;
                voto          <= 3'd0;
                alvo_lobo     <= 3'd0;
                alvo_medico   <= SEM_ALVO;
                lobo_escolheu <= 1'b0;
            end else if (bus.inc_jogador) begin
                jogador_atual <= (jogador_atual == ULTIMO_JOG) ? 3'd0 : jogador_atual + 3'd1;
                jogou         <= 1'b0;
            end
        end
    end

    assign bus.jogador_atual     = jogador_atual;
    assign bus.CJ_fim            = (jogador_atual == ULTIMO_JOG);
    assign bus.jogador_vivo      = vivos_ext[jogador_atual];
    assign bus.classe_atual      = eh_lobo ? 2'd1 : (eh_medico ? 2'd2 : 2'd0);
    assign bus.jogou             = jogou;
    assign bus.votou             = votou;
    assign bus.acertou           = votou && (voto == lobo_idx);
    assign bus.houve_morte       = houve_morte;
    assign bus.morto_noite       = morto_noite;
    assign bus.vivos             = vivos;
    assign bus.sinal_lobo_ganhou = vivos_ext[lobo_idx] && ($countones(vivos) <= 2);
endmodule

// File: tb/tb_registro_jogadores.sv
// Scoreboard bench for registro_jogadores: directed game rounds followed by
// random strobe traffic, checked against a role/array-level game model.
module tb_registro_jogadores;
    localparam int N_JOG = 5;

    logic clock;
    logic reset;
    registro_jogadores_if bus();

    registro_jogadores dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        bit       rst_n;
        bit       rst_global;
        bit       e_seed;
        bit [7:0] seed;
        bit       zera;
        bit       inc;
        bit       proc_acao;
        bit       vot;
        bit [2:0] alvo;
        bit       conf;
        bit       aval;
        bit       morra;
    } stim_t;

    typedef struct {
        string      nome;
        logic [2:0] jogador_atual;
        logic       cj_fim;
        logic       jogador_vivo;
        logic [1:0] classe;
        logic       jogou;
        logic       votou;
        logic       acertou;
        logic       houve;
        logic [2:0] morto;
        logic [4:0] vivos;
        logic       lobo_ganhou;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Game model: who is who, who is alive, and who chose whom (-1 = nobody).
    int m_lobo, m_medico, m_cont, m_voto, m_morto, m_alvo_lobo, m_alvo_medico;
    bit m_vivo[N_JOG];
    bit m_jogou, m_votou, m_houve;

    function automatic void model_reset();
        m_lobo = 0; m_medico = 1; m_cont = 0; m_voto = 0; m_morto = 0;
        m_alvo_lobo = -1; m_alvo_medico = -1;
        m_jogou = 0; m_votou = 0; m_houve = 0;
        for (int i = 0; i < N_JOG; i++) m_vivo[i] = 1'b1;
    endfunction

    function automatic void model_update(stim_t s);
        int  a;
        bit  alvo_ok;
        bit  old_jogou;
        bit  old_votou;
        int  old_voto;
        if (!s.rst_n || s.rst_global) begin
            model_reset();
            return;
        end
        a         = int'(s.alvo);
        alvo_ok   = (a < N_JOG) ? m_vivo[a] : 1'b0;
        old_jogou = m_jogou;
        old_votou = m_votou;
        old_voto  = m_voto;
        if (s.aval) begin
            if (m_alvo_lobo >= 0 && m_alvo_lobo != m_alvo_medico) begin
                m_vivo[m_alvo_lobo] = 1'b0;
                m_morto = m_alvo_lobo;
                m_houve = 1'b1;
            end else begin
                m_houve = 1'b0;
            end
            m_alvo_lobo = -1;
        end
        if (s.morra && old_votou) m_vivo[old_voto] = 1'b0;
        if (s.proc_acao && s.conf && !old_jogou && alvo_ok) begin
            if (m_cont == m_lobo) begin
                if (a != m_lobo) begin
                    m_alvo_lobo = a;
                    m_jogou = 1'b1;
                end
            end else begin
                if (m_cont == m_medico) m_alvo_medico = a;
                m_jogou = 1'b1;
            end
        end
        if (s.vot && s.conf && !old_votou && alvo_ok) begin
            m_voto = a;
            m_votou = 1'b1;
        end
        if (s.e_seed) begin
            m_lobo   = int'(s.seed[2:0]) % N_JOG;
            m_medico = (m_lobo + 1 + int'(s.seed[5:4])) % N_JOG;
            for (int i = 0; i < N_JOG; i++) m_vivo[i] = 1'b1;
        end else if (s.zera) begin
            m_cont = 0; m_jogou = 0; m_votou = 0; m_voto = 0;
            m_alvo_lobo = -1; m_alvo_medico = -1;
        end else if (s.inc) begin
            m_cont = (m_cont + 1) % N_JOG;
            m_jogou = 0;
        end
    endfunction

    function automatic exp_t model_expected(string nome);
        exp_t e;
        int   n_vivos = 0;
        e.nome          = nome;
        e.jogador_atual = 3'(m_cont);
        e.cj_fim        = (m_cont == N_JOG - 1);
        e.jogador_vivo  = m_vivo[m_cont];
        e.classe        = (m_cont == m_lobo) ? 2'd1 : ((m_cont == m_medico) ? 2'd2 : 2'd0);
        e.jogou         = m_jogou;
        e.votou         = m_votou;
        e.acertou       = m_votou && (m_voto == m_lobo);
        e.houve         = m_houve;
        e.morto         = 3'(m_morto);
        for (int i = 0; i < N_JOG; i++) begin
            e.vivos[i] = m_vivo[i];
            n_vivos += int'(m_vivo[i]);
        end
        e.lobo_ganhou   = m_vivo[m_lobo] && (n_vivos <= 2);
        return e;
    endfunction

    function automatic stim_t idle_stim();
        stim_t s;
        s = '{default: 0};
        s.rst_n = 1'b1;
        return s;
    endfunction

    task automatic drive(stim_t s);
        reset                  = s.rst_n;
        bus.rst_global         = s.rst_global;
        bus.e_seed_reg         = s.e_seed;
        bus.seed               = s.seed;
        bus.zera_CJ            = s.zera;
        bus.inc_jogador        = s.inc;
        bus.processar_acao     = s.proc_acao;
        bus.votacao            = s.vot;
        bus.alvo               = s.alvo;
        bus.confirma           = s.conf;
        bus.avaliar_eliminacao = s.aval;
        bus.morra              = s.morra;
    endtask

    // One clock of stimulus; the post-edge expectation goes to the scoreboard.
    task automatic apply_stimulus(stim_t s, string nome);
        drive(s);
        @(posedge clock);
        model_update(s);
        #1;
        drive(idle_stim());
        sb.push_back(model_expected(nome));
    endtask

    task automatic cmp(string nome, string campo, logic [7:0] got, logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s.%s got %0h expected %0h", nome, campo, got, exp);
        end
    endtask

    task automatic check_output(exp_t e);
        cmp(e.nome, "jogador_atual", 8'(bus.jogador_atual), 8'(e.jogador_atual));
        cmp(e.nome, "CJ_fim", 8'(bus.CJ_fim), 8'(e.cj_fim));
        cmp(e.nome, "jogador_vivo", 8'(bus.jogador_vivo), 8'(e.jogador_vivo));
        cmp(e.nome, "classe_atual", 8'(bus.classe_atual), 8'(e.classe));
        cmp(e.nome, "jogou", 8'(bus.jogou), 8'(e.jogou));
        cmp(e.nome, "votou", 8'(bus.votou), 8'(e.votou));
        cmp(e.nome, "acertou", 8'(bus.acertou), 8'(e.acertou));
        cmp(e.nome, "houve_morte", 8'(bus.houve_morte), 8'(e.houve));
        cmp(e.nome, "morto_noite", 8'(bus.morto_noite), 8'(e.morto));
        cmp(e.nome, "vivos", 8'(bus.vivos), 8'(e.vivos));
        cmp(e.nome, "sinal_lobo_ganhou", 8'(bus.sinal_lobo_ganhou), 8'(e.lobo_ganhou));
    endtask

    // Monitor: outputs are registered, so each queued expectation is
    // compared on the falling edge after the stimulus edge.
    always @(negedge clock) begin
        if (sb.size() > 0) begin
            check_output(sb.pop_front());
        end
    end

    task automatic do_reset(string nome);
        stim_t s = idle_stim();
        s.rst_n = 1'b0;
        apply_stimulus(s, nome);
    endtask

    task automatic do_seed(bit [7:0] seed);
        stim_t s = idle_stim();
        s.e_seed = 1'b1;
        s.seed   = seed;
        apply_stimulus(s, "seed");
    endtask

    task automatic do_zera();
        stim_t s = idle_stim();
        s.zera = 1'b1;
        apply_stimulus(s, "zera");
    endtask

    task automatic do_inc(int n);
        stim_t s = idle_stim();
        s.inc = 1'b1;
        for (int i = 0; i < n; i++) apply_stimulus(s, "inc");
    endtask

    task automatic do_night(bit [2:0] alvo);
        stim_t s = idle_stim();
        s.proc_acao = 1'b1;
        s.conf      = 1'b1;
        s.alvo      = alvo;
        apply_stimulus(s, "night");
    endtask

    task automatic do_vote(bit [2:0] alvo);
        stim_t s = idle_stim();
        s.vot  = 1'b1;
        s.conf = 1'b1;
        s.alvo = alvo;
        apply_stimulus(s, "vote");
    endtask

    task automatic do_aval();
        stim_t s = idle_stim();
        s.aval = 1'b1;
        apply_stimulus(s, "avaliar");
    endtask

    task automatic do_morra();
        stim_t s = idle_stim();
        s.morra = 1'b1;
        apply_stimulus(s, "morra");
    endtask

    initial begin
        stim_t s;
        drive(idle_stim());
        reset = 1'b0;
        model_reset();

        do_reset("reset");
        apply_stimulus(idle_stim(), "idle");

        // seed 0x17: wolf 2, doctor 4
        do_seed(8'h17);
        do_zera();
        do_inc(2);
        do_night(3'd2);
        do_night(3'd6);
        do_night(3'd0);
        do_night(3'd3);
        do_inc(2);
        do_night(3'd1);
        do_aval();

        // doctor saves the wolf's target
        do_zera();
        do_inc(2);
        do_night(3'd3);
        do_inc(2);
        do_night(3'd3);
        do_aval();

        // day votes: correct guess, then a wrong one that gets eliminated
        do_zera();
        do_vote(3'd2);
        do_vote(3'd1);
        do_zera();
        do_vote(3'd0);
        do_vote(3'd1);
        do_morra();

        // third kill leaves wolf plus one citizen
        do_zera();
        do_inc(2);
        do_night(3'd3);
        do_inc(2);
        do_night(3'd4);
        do_aval();
        apply_stimulus(idle_stim(), "wolf_win");
        do_inc(1);

        // reset in the middle of a vote, then rst_global after a new game
        do_zera();
        do_vote(3'd2);
        do_reset("reset_mid_vote");
        do_seed(8'h3C);
        do_zera();
        do_vote(3'd4);
        s = idle_stim();
        s.rst_global = 1'b1;
        apply_stimulus(s, "rst_global");

        // random strobe traffic
        for (int i = 0; i < 600; i++) begin
            s = idle_stim();
            s.rst_n      = ($urandom_range(0, 79) != 0);
            s.rst_global = ($urandom_range(0, 79) == 0);
            s.e_seed     = ($urandom_range(0, 29) == 0);
            s.seed       = 8'($urandom);
            s.zera       = ($urandom_range(0, 9) == 0);
            s.inc        = ($urandom_range(0, 2) == 0);
            s.proc_acao  = ($urandom_range(0, 1) == 0);
            s.vot        = ($urandom_range(0, 2) == 0);
            s.conf       = ($urandom_range(0, 1) == 0);
            s.alvo       = 3'($urandom_range(0, 7));
            s.aval       = ($urandom_range(0, 7) == 0);
            s.morra      = ($urandom_range(0, 9) == 0);
            apply_stimulus(s, "random");
        end

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clock);
        if (sb.size() > 0) begin
            errors++;
            $display("[TB] FAIL drain got %0d pending expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL timeout got running expected finished");
        $fatal(1, "[TB] timeout");
    end
endmodule

// File: doc/registro_jogadores.md
# registro_jogadores

Player-state datapath answering the game control FSM: it receives that FSM's strobes (`rst_global`, `e_seed_reg`, `zera_CJ`, `inc_jogador`, `processar_acao`, `avaliar_eliminacao`, `votacao`, `morra`) and returns the status flags it branches on (`CJ_fim`, `jogador_vivo`, `jogou`, `votou`, `acertou`, `sinal_lobo_ganhou`). It holds role assignment, the alive mask, the player counter, night-action targets and the day vote for a 5-player game with one wolf, one doctor and three citizens.

## Interface
- `N_JOG`, 5, number of players (fixed by the design; index width 3)
- `clock`  input  1  system clock, all state on rising edge
- `reset`  input  1  synchronous, active-low (0 = reset)
- `rst_global`  input  1  clear all game state (same effect as reset)
- `e_seed_reg`  input  1  latch roles from `seed`
- `seed`  input  8  free-running seed value
- `zera_CJ`  input  1  clear player counter and night/vote registers
- `inc_jogador`  input  1  advance player counter
- `processar_acao`  input  1  night turn of current player active
- `votacao`  input  1  day vote window active
- `alvo`  input  3  selected target index (night action and vote)
- `confirma`  input  1  one-cycle confirm pulse
- `avaliar_eliminacao`  input  1  resolve night kill
- `morra`  input  1  eliminate voted player
- `jogador_atual`  output  3  player counter
- `CJ_fim`  output  1  `jogador_atual == N_JOG-1`
- `jogador_vivo`  output  1  `vivos[jogador_atual]`
- `classe_atual`  output  2  role of current player: 0 citizen, 1 wolf, 2 doctor
- `jogou`  output  1  current player's night action accepted
- `votou`  output  1  vote accepted
- `acertou`  output  1  `votou && voto == lobo_idx`
- `houve_morte`  output  1  last night resolution killed someone
- `morto_noite`  output  3  index killed at night
- `vivos`  output  5  alive mask
- `sinal_lobo_ganhou`  output  1  wolf alive and popcount(`vivos`) ≤ 2

## Operation
- Role latch on `e_seed_reg`: `lobo_idx = seed[2:0] mod 5`; `medico_idx = (lobo_idx + 1 + seed[5:4]) mod 5`. The doctor is never the wolf. `vivos` is set to 5'b11111.
- Counter: `zera_CJ` → 0; else `inc_jogador` → +1, wrapping from 4 to 0.
- Night (`processar_acao=1`, `confirma=1`):
  - A target is valid when `alvo < 5` and `vivos[alvo] = 1`.
  - Wolf: also requires `alvo ≠ lobo_idx`; stores `alvo_lobo`, sets `lobo_escolheu`.
  - Doctor: stores `alvo_medico` (self allowed).
  - Citizen: any valid target is accepted and discarded, so roles are not revealed.
  - A valid target sets `jogou`. An invalid target is ignored and `jogou` stays 0.
  - Once `jogou` is set, further confirms are ignored until the counter moves.
- `jogou` clears on `inc_jogador`, `zera_CJ` or `rst_global`.
- `avaliar_eliminacao`:
  - If `lobo_escolheu` and `alvo_lobo ≠ alvo_medico`: clear `vivos[alvo_lobo]`, `morto_noite ← alvo_lobo`, `houve_morte ← 1`.
  - Otherwise `houve_morte ← 0`.
  - Always clears `lobo_escolheu`.
- Day (`votacao=1`, `confirma=1`, `votou=0`): a valid target (`alvo < 5`, alive) is stored in `voto` and sets `votou`. Invalid targets are ignored.
- `morra`: clear `vivos[voto]` when `votou=1`.
- `votou` clears on `zera_CJ` or `rst_global`.
- Confirms with both `processar_acao` and `votacao` low are ignored.
- Priority: reset/`rst_global` > `e_seed_reg` > `zera_CJ` > `inc_jogador`. `avaliar_eliminacao`, `morra` and action capture are evaluated independently in the same cycle.

## Timing
- Reset values:
  - `jogador_atual=0`, `vivos=5'b11111`, `lobo_idx=0`, `medico_idx=1`, `voto=0`, `morto_noite=0`
  - `jogou=0`, `votou=0`, `houve_morte=0`
  - Derived: `CJ_fim=0`, `jogador_vivo=1`, `classe_atual=1`, `acertou=0`, `sinal_lobo_ganhou=0`
- All registers update on the clock edge after the strobe; derived flags are combinational from registers and are valid the same cycle.
- The FSM's Moore state lasts ≥1 cycle, so a strobe is sampled at least once. Level-held strobes (`processar_acao`, `votacao`) are idempotent via `jogou`/`votou` locking.
- Mid-game reset or `rst_global` restores reset values within one cycle. Roles return to the default and stay there until the next `e_seed_reg`.
- `sinal_lobo_ganhou` is valid the cycle after `avaliar_eliminacao` or `morra`, which satisfies the control FSM's next-cycle check state.

## Test plan
- Latch: `seed=8'h17`, pulse `e_seed_reg` → `lobo_idx=2`, `medico_idx=4`, `vivos=11111`. At `jogador_atual=2`, `classe_atual=1`.
- Night kill: wolf(2) confirms `alvo=0`, doctor(4) confirms `alvo=1`, then `avaliar_eliminacao` → `vivos=11110`, `morto_noite=0`, `houve_morte=1`.
- Doctor save: wolf `alvo=3`, doctor `alvo=3` → `vivos` unchanged, `houve_morte=0`. Wolf confirming `alvo=2` (self) or `alvo=6` → `jogou` stays 0.
- Vote: `votacao=1`, confirm `alvo=2` → `votou=1`, `acertou=1`. Repeat with `alvo=1` → `acertou=0`; then `morra` → `vivos[1]=0`.
- Wolf win: kill players 0, 1, 3 over rounds → `vivos=10100`, `sinal_lobo_ganhou=1` the cycle after the third kill. Also check `CJ_fim=1` at counter 4 and wrap to 0 on `inc_jogador`.
- Reset mid-vote: drive `reset=0` for one cycle while `votou=1` → every output at its reset value on the next edge.
